// File: rtl/atrover_pkg.sv
// ---------------------------------------------------------------------------
// atrover_pkg
// Shared constants for the atrover SoC peripherals: the IO register index map
// and the UART payload/status layout used when the CPU reads UART0 RX.
// No ports (package).
// ---------------------------------------------------------------------------
package atrover_pkg;

    localparam int UART_DATA_BITS = 8;

    // Bit positions inside the 32-bit word returned by an IO read of UART0 RX.
    localparam int RX_VALID_BIT = 31;
    localparam int RX_OVF_BIT   = 30;

    typedef enum logic [2:0] {
        IO_LEDS       = 3'd0,
        IO_UART0_TX   = 3'd1,
        IO_UART0_RX   = 3'd2,
        IO_UART0_STAT = 3'd3,
        IO_TIMER      = 3'd4
    } ioReg_e;

    // Assembles the CPU-visible RX word: payload in the low bits, the
    // valid and overflow flags in the top two bits.
    function automatic logic [31:0] packRxWord(input logic                      valid,
                                               input logic                      ovf,
                                               input logic [UART_DATA_BITS-1:0] data);
        logic [31:0] word;
        word                       = '0;
        word[UART_DATA_BITS-1:0]   = data;
        word[RX_OVF_BIT]           = ovf;
        word[RX_VALID_BIT]         = valid;
        return word;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the receive strobe, CPU pop/clear requests and the FIFO status/read
// outputs of uart_rx_fifo.
//   master : drives rx_valid, rx_data, pop, ovf_clr; observes the rest
//   slave  : the FIFO itself; drives rd_valid, rd_data, level, empty, full,
//            overflow
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if
    import atrover_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = 16
);
    localparam int LVL_WL = $clog2(DEPTH + 1);

    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 pop;
    logic                 ovf_clr;
    logic                 rd_valid;
    logic [DATA_BITS-1:0] rd_data;
    logic [LVL_WL-1:0]    level;
    logic                 empty;
    logic                 full;
    logic                 overflow;

    modport master (
        output rx_valid, rx_data, pop, ovf_clr,
        input  rd_valid, rd_data, level, empty, full, overflow
    );

    modport slave (
        input  rx_valid, rx_data, pop, ovf_clr,
        output rd_valid, rd_data, level, empty, full, overflow
    );

endinterface

// File: rtl/uart_rx_fifo_sdp_ram.sv
// ---------------------------------------------------------------------------
// fifo_sdp_ram
// Simple dual-port storage for the RX FIFO: one synchronous write port, one
// read port with a registered output. The array itself has no reset so it can
// map onto distributed RAM; only the output register is cleared.
//   clk, resetn : system clock, synchronous active-low reset (output reg only)
//   wrEn_i, wrAddr_i, wrData_i : write port
//   rdEn_i, rdAddr_i           : read request; data appears next cycle
//   rdData_o                   : registered read data, held between reads
// ---------------------------------------------------------------------------
module fifo_sdp_ram #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wrEn_i,
    input  logic [ADDR_W-1:0]    wrAddr_i,
    input  logic [DATA_BITS-1:0] wrData_i,
    input  logic                 rdEn_i,
    input  logic [ADDR_W-1:0]    rdAddr_i,
    output logic [DATA_BITS-1:0] rdData_o
);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rdData_q;

    // Storage array write port, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    // Read register: a read of the slot being written in the same cycle
    // returns the old contents, which is what a full-FIFO write+pop needs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive FIFO between the UART0 receiver and the CPU's RX register. Bytes
// strobed in by the receiver are queued; each accepted CPU pop returns the
// oldest byte one cycle later with a one-cycle rd_valid pulse. Bytes arriving
// while full (with no simultaneous pop) are dropped and a sticky overflow flag
// is raised until the CPU clears it.
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : uart_rx_fifo_if.slave (rx_valid/rx_data in, pop, ovf_clr,
//            rd_valid/rd_data out, level/empty/full/overflow status)
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import atrover_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = 16
) (
    input  logic           clk,
    input  logic           resetn,
    uart_rx_fifo_if.slave  bus
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_WL = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
    logic [LVL_WL-1:0]    level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 empty_q;
    logic                 full_q;
    logic                 rdValid_q;
    logic                 doWrite;
    logic                 doPop;
    logic                 dropByte;
    logic [DATA_BITS-1:0] ramRdData;

    // Accept/drop decisions and next-state values. A pop only counts when
    // something is stored, so a write into an empty FIFO never falls through.
    // A write into a full FIFO is accepted only if a pop frees a slot in the
    // same cycle (full implies non-empty, so that pop is always accepted).
    // When a byte is dropped the overflow set takes priority over a clear.
    always_comb begin
        doPop      = bus.pop && !empty_q;
        doWrite    = bus.rx_valid && (!full_q || bus.pop);
        dropByte   = bus.rx_valid && full_q && !bus.pop;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (doWrite) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doWrite, doPop})
            2'b10:   level_d = level_q + LVL_WL'(1);
            2'b01:   level_d = level_q - LVL_WL'(1);
            default: level_d = level_q;
        endcase
        if (dropByte) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control registers. empty/full are decoded from the next level value so
    // they are registered yet track the level counter in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            rdValid_q  <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            empty_q    <= (level_d == '0);
            full_q     <= (level_d == LVL_WL'(DEPTH));
            overflow_q <= overflow_d;
            rdValid_q  <= doPop;
        end
    end

    fifo_sdp_ram #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .ADDR_W    (PTR_W)
    ) u_ram (
        .clk      (clk),
        .resetn   (resetn),
        .wrEn_i   (doWrite),
        .wrAddr_i (wrPtr_q),
        .wrData_i (bus.rx_data),
        .rdEn_i   (doPop),
        .rdAddr_i (rdPtr_q),
        .rdData_o (ramRdData)
    );

    assign bus.rd_valid = rdValid_q;
    assign bus.rd_data  = ramRdData;
    assign bus.level    = level_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
- REQ-001: Parameter DATA_BITS, default 8, UART payload width.
- REQ-002: Parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
- REQ-003: Derived constant LVL_WL = $clog2(DEPTH+1), width of the level output.
- REQ-004: Port clk, input, 1, single system clock; all logic on posedge clk.
- REQ-005: Port resetn, input, 1, reset; synchronous, active-low.
- REQ-006: Port rx_valid, input, 1, one-cycle strobe from the UART receiver.
- REQ-007: Port rx_data, input, DATA_BITS, received byte; qualified by rx_valid.
- REQ-008: Port pop, input, 1, CPU read request for one entry (IO read of the UART0 RX register).
- REQ-009: Port ovf_clr, input, 1, clears the sticky overflow flag.
- REQ-010: Port rd_valid, output, 1, one-cycle pulse marking rd_data valid.
- REQ-011: Port rd_data, output, DATA_BITS, popped byte.
- REQ-012: Port level, output, LVL_WL, number of stored entries.
- REQ-013: Port empty, output, 1, high when level == 0.
- REQ-014: Port full, output, 1, high when level == DEPTH.
- REQ-015: Port overflow, output, 1, sticky flag: a byte was dropped.

Function
- REQ-016: When rx_valid=1 and the FIFO is not full, rx_data SHALL be written at the write pointer, and the write pointer SHALL advance by 1, modulo DEPTH.
- REQ-017: When pop=1 and the FIFO is not empty, the entry at the read pointer SHALL appear on rd_data with rd_valid=1 exactly one cycle later, and the read pointer SHALL advance by 1, modulo DEPTH.
- REQ-018: A pop while empty SHALL be ignored: no pointer change, rd_valid=0 next cycle, and rd_data holds its last value.
- REQ-019: rd_valid SHALL be high for exactly one cycle per accepted pop.
- REQ-020: Between pops, rd_data SHALL hold the last popped value.
- REQ-021: An rx_valid while full and without pop SHALL drop the byte, leave the contents unchanged, and set overflow.
- REQ-022: An rx_valid while full with pop=1 in the same cycle SHALL accept both operations; level stays DEPTH; overflow unchanged.
- REQ-023: An rx_valid and pop in the same cycle while empty SHALL write only; the pop is ignored; level becomes 1. There is no fall-through.
- REQ-024: Simultaneous accepted write and read at any other level SHALL leave level unchanged.
- REQ-025: level, empty and full SHALL be registered and reflect all operations of the previous cycle.
- REQ-026: overflow SHALL stay set until ovf_clr=1.
- REQ-027: If ovf_clr and a new overflow event occur in the same cycle, overflow SHALL stay 1 (set wins).
- REQ-028: Pointers SHALL be log2(DEPTH) bits wide, with wrap-around by natural overflow.
- REQ-029: Full and empty SHALL be derived from an explicit level counter, not from pointer equality.

Reset
- REQ-030: With resetn=0 at a clock edge, the following SHALL be set: pointers 0, level 0, empty 1, full 0, overflow 0, rd_valid 0, rd_data 0.
- REQ-031: Storage contents need not be reset.
- REQ-032: A reset asserted mid-operation SHALL discard all stored entries and any pending rd_valid.
- REQ-033: rx_valid, pop and ovf_clr SHALL be ignored while resetn=0.

Structure
- REQ-034: The IO register index enumeration and UART constants (DATA_BITS, RX register bit positions: bit31 valid, bit30 overflow) SHALL live in the shared package atrover_pkg.
- REQ-035: The storage array SHALL be one sub-module, fifo_sdp_ram: a simple dual-port RAM, sync write, registered read, DEPTH x DATA_BITS, inferable as distributed RAM.
- REQ-036: Pointer, level and flag control SHALL remain in uart_rx_fifo.

Verification
- REQ-037: Reset, then write 0x41, 0x42, 0x43 on separate cycles -> level=3, empty=0; three pops -> rd_data 0x41, 0x42, 0x43, each with a one-cycle rd_valid, then empty=1.
- REQ-038: Write 16 bytes 0x00..0x0F -> full=1; write 0xAA -> overflow=1, level=16; popping all 16 -> 0x00..0x0F, and 0xAA is never seen.
- REQ-039: Full FIFO, rx_valid=1 with 0x55 and pop=1 in the same cycle -> rd_data=0x00, level=16, overflow=0; the 16th subsequent pop returns 0x55.
- REQ-040: Empty FIFO, pop=1 -> rd_valid=0; rx_valid and pop in the same cycle -> level=1, rd_valid=0.
- REQ-041: Overflow set; ovf_clr=1 together with a new dropped byte -> overflow stays 1; ovf_clr alone next cycle -> overflow=0.
- REQ-042: Level 5 with resetn=0 for one cycle -> level=0, empty=1, and the next pop yields rd_valid=0.
